// File: rtl/cv32e40p_fetch_queue.sv
// Instruction prefetch queue: issues word-aligned OBI fetches and buffers the
// responses, with address/error tags, for the IF-stage aligner.

package cv32e40p_fetch_queue_pkg;

  typedef struct packed {
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        err;
  } fq_entry_t;

endpackage

module cv32e40p_fetch_queue
  import cv32e40p_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned PULP_OBI        = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_i,
  input  logic                         branch_i,
  input  logic [31:0]                  branch_addr_i,
  output logic                         instr_req_o,
  output logic [31:0]                  instr_addr_o,
  input  logic                         instr_gnt_i,
  input  logic                         instr_rvalid_i,
  input  logic [31:0]                  instr_rdata_i,
  input  logic                         instr_err_i,
  output logic                         fetch_valid_o,
  input  logic                         fetch_ready_i,
  output logic [31:0]                  fetch_rdata_o,
  output logic [31:0]                  fetch_addr_o,
  output logic                         fetch_err_o,
  output logic [$clog2(DEPTH):0]       level_o,
  output logic                         busy_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_GNT_BR = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              run_q;
  logic [31:0]       next_addr_q;
  logic [31:0]       br_target_q;
  logic [CNT_W-1:0]  outstanding_q;
  logic [CNT_W-1:0]  discard_q;
  logic [CNT_W-1:0]  level_q;
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [PTR_W-1:0]  tag_wptr_q, tag_rptr_q;
  fq_entry_t         fifo_q [DEPTH];
  logic [31:0]       tag_q  [DEPTH];

  logic        branch, gnt, rvalid;
  logic [31:0] br_aligned;
  logic        credit, credit_br;
  logic        br_redirect, br_hold, gnt_stale;
  logic        drop, rsp_keep, empty, bypass, push, pop;
  fq_entry_t   rsp_entry, head;
  logic        unused_addr_lsb;

  // Everything is held quiet until the first clock after reset release.
  assign branch     = branch_i & run_q;
  assign rvalid     = instr_rvalid_i & run_q;
  assign gnt        = instr_gnt_i & instr_req_o;
  assign br_aligned = {branch_addr_i[31:2], 2'b00};

  assign unused_addr_lsb = ^branch_addr_i[1:0];

  // Reserve a FIFO slot for every transaction before it is issued.
  assign credit    = run_q
                   && (({1'b0, outstanding_q} + {1'b0, level_q}) < (CNT_W+1)'(DEPTH))
                   && (outstanding_q < CNT_W'(MAX_OUTSTANDING));
  assign credit_br = run_q && (outstanding_q < CNT_W'(MAX_OUTSTANDING));

  // A branch either redirects the bus now or, under strict OBI, waits for the grant.
  assign br_redirect = branch & ((state_q == IDLE) |
                                 ((PULP_OBI != 0) & (state_q == WAIT_GNT)));
  assign br_hold     = branch & ~br_redirect;
  assign gnt_stale   = gnt & ((state_q == WAIT_GNT_BR) | br_hold);

  assign drop     = rvalid & (discard_q != '0);
  assign rsp_keep = rvalid & ~drop & ~branch;
  assign empty    = (level_q == '0);
  assign bypass   = empty & rsp_keep;
  assign push     = rsp_keep & ~(bypass & fetch_ready_i);
  assign pop      = ~empty & fetch_ready_i & ~branch;

  assign rsp_entry = '{rdata: instr_rdata_i, addr: tag_q[tag_rptr_q], err: instr_err_i};
  assign head      = fifo_q[rptr_q];

  assign fetch_valid_o = ~empty | bypass;
  assign fetch_rdata_o = ~empty ? head.rdata : (bypass ? rsp_entry.rdata : 32'd0);
  assign fetch_addr_o  = ~empty ? head.addr  : (bypass ? rsp_entry.addr  : 32'd0);
  assign fetch_err_o   = ~empty ? head.err   : (bypass & rsp_entry.err);
  assign level_o       = level_q;
  assign busy_o        = (outstanding_q != '0) | (discard_q != '0) |
                         (state_q == WAIT_GNT_BR);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (instr_req_o && !gnt) state_d = WAIT_GNT;
      end
      WAIT_GNT: begin
        if (gnt)               state_d = IDLE;
        else if (br_hold)      state_d = WAIT_GNT_BR;
        else if (!instr_req_o) state_d = IDLE;
      end
      WAIT_GNT_BR: begin
        if (gnt) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: bus request and address
  always_comb begin
    instr_req_o  = 1'b0;
    instr_addr_o = next_addr_q;
    case (state_q)
      IDLE: begin
        if (branch) begin
          instr_req_o  = req_i & credit_br;
          instr_addr_o = br_aligned;
        end else begin
          instr_req_o  = req_i & credit;
        end
      end
      WAIT_GNT: begin
        if (br_redirect) begin
          instr_req_o  = req_i & credit_br;
          instr_addr_o = br_aligned;
        end else begin
          instr_req_o  = 1'b1;
        end
      end
      WAIT_GNT_BR: begin
        instr_req_o = 1'b1;
      end
      default: begin
        instr_req_o = 1'b0;
      end
    endcase
  end

  // Fetch address, branch latch and transaction counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q         <= 1'b0;
      next_addr_q   <= '0;
      br_target_q   <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      run_q <= 1'b1;
      if (gnt) begin
        if (br_hold)                     next_addr_q <= br_aligned;
        else if (state_q == WAIT_GNT_BR) next_addr_q <= br_target_q;
        else                             next_addr_q <= instr_addr_o + 32'd4;
      end else if (br_redirect) begin
        next_addr_q <= br_aligned;
      end
      if (br_hold && !gnt) br_target_q <= br_aligned;
      outstanding_q <= outstanding_q + CNT_W'(gnt) - CNT_W'(rvalid);
      // Every response still in flight at a branch belongs to the old stream.
      if (branch) discard_q <= outstanding_q - CNT_W'(rvalid) + CNT_W'(gnt_stale);
      else        discard_q <= discard_q - CNT_W'(drop) + CNT_W'(gnt_stale);
    end
  end

  // Address tags recorded at grant, consumed in order by responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wptr_q <= '0;
      tag_rptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else begin
      if (gnt) begin
        tag_q[tag_wptr_q] <= instr_addr_o;
        tag_wptr_q        <= tag_wptr_q + PTR_W'(1);
      end
      if (rvalid) tag_rptr_q <= tag_rptr_q + PTR_W'(1);
    end
  end

  // Response FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else if (branch) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= rsp_entry;
        wptr_q         <= wptr_q + PTR_W'(1);
      end
      if (pop) rptr_q <= rptr_q + PTR_W'(1);
      level_q <= level_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: tb/tb_cv32e40p_fetch_queue.sv
// Directed bench for cv32e40p_fetch_queue: a one-cycle-latency OBI slave,
// a scoreboard of expected fetch words and a monitor on the aligner handshake.

module tb_cv32e40p_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] ERR_ADDR = 32'h0000_0500;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk, rst_n;
  logic        req_i, branch_i;
  logic [31:0] branch_addr_i;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i, instr_rvalid_i, instr_err_i;
  logic [31:0] instr_rdata_i;
  logic        fetch_valid_o, fetch_ready_i, fetch_err_o;
  logic [31:0] fetch_rdata_o, fetch_addr_o;
  logic [$clog2(DEPTH):0] level_o;
  logic        busy_o;

  int   checks, errors;
  int   gnt_total;
  logic rsp_hold;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [31:0] pend[$];

  cv32e40p_fetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(2), .PULP_OBI(0)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .branch_i(branch_i),
    .branch_addr_i(branch_addr_i), .instr_req_o(instr_req_o),
    .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .instr_err_i(instr_err_i), .fetch_valid_o(fetch_valid_o),
    .fetch_ready_i(fetch_ready_i), .fetch_rdata_o(fetch_rdata_o),
    .fetch_addr_o(fetch_addr_o), .fetch_err_o(fetch_err_o),
    .level_o(level_o), .busy_o(busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] bus_data(input logic [31:0] a);
    return (a == 32'h0000_0600) ? 32'hDEAD_BEEF : ~a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] a);
    exp_t e;
    e.addr = a;
    e.data = bus_data(a);
    e.err  = (a == ERR_ADDR);
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic branch_to(input logic [31:0] a);
    branch_addr_i = a;
    branch_i      = 1'b1;
    step();
    branch_i      = 1'b0;
  endtask

  task automatic run(input int n);
    int base;
    base  = gnt_total;
    req_i = 1'b1;
    for (int c = 0; c < 60; c++) begin
      step();
      if (gnt_total - base >= n) break;
    end
    req_i = 1'b0;
    chk("grant_count", 32'(gnt_total - base), 32'(n));
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!busy_o && !fetch_valid_o) begin
        idle = 1'b1;
        break;
      end
    end
    chk("drain_idle", 32'(idle), 32'd1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    step();
  endtask

  // OBI slave: grants recorded mid-cycle, answered in the following cycle.
  initial begin
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    instr_err_i    = 1'b0;
    gnt_total      = 0;
    forever begin
      @(negedge clk);
      if (rst_n && instr_req_o && instr_gnt_i) begin
        pend.push_back(instr_addr_o);
        gnt_total++;
      end
      @(posedge clk);
      #2;
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = '0;
      instr_err_i    = 1'b0;
      if (!rst_n) begin
        pend.delete();
      end else if (!rsp_hold && pend.size() > 0) begin
        logic [31:0] a;
        a = pend.pop_front();
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = bus_data(a);
        instr_err_i    = (a == ERR_ADDR);
      end
    end
  end

  // Monitor: every accepted word is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && fetch_valid_o && fetch_ready_i && !branch_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got addr 0x%08h, expected none", fetch_addr_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("fetch_addr", fetch_addr_o, mon_e.addr);
        chk("fetch_rdata", fetch_rdata_o, mon_e.data);
        chk("fetch_err", 32'(fetch_err_o), 32'(mon_e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    checks = 0; errors = 0;
    rst_n = 1'b0; req_i = 1'b1; branch_i = 1'b0; branch_addr_i = '0;
    instr_gnt_i = 1'b1; fetch_ready_i = 1'b1; rsp_hold = 1'b0;

    // Reset state with req_i already high
    repeat (2) step();
    chk("rst_instr_req", 32'(instr_req_o), 32'd0);
    chk("rst_instr_addr", instr_addr_o, 32'd0);
    chk("rst_fetch_valid", 32'(fetch_valid_o), 32'd0);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    rst_n = 1'b1; req_i = 1'b0;
    step();

    // Sequential stream from 0x80 with zero-wait consumer
    branch_to(32'h0000_0080);
    for (int i = 0; i < 8; i++) exp_push(32'h0000_0080 + 32'(4 * i));
    run(8);
    wait_idle();

    // Consumer stalled: credit limits issue to DEPTH words
    fetch_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) exp_push(32'h0000_00A0 + 32'(4 * i));
    base  = gnt_total;
    req_i = 1'b1;
    repeat (8) step();
    chk("stall_grants", 32'(gnt_total - base), 32'd4);
    @(negedge clk);
    chk("stall_req_low", 32'(instr_req_o), 32'd0);
    chk("stall_level_full", 32'(level_o), 32'(DEPTH));
    step();
    fetch_ready_i = 1'b1;
    step();
    fetch_ready_i = 1'b0;
    base = gnt_total;
    repeat (5) step();
    chk("one_pop_one_grant", 32'(gnt_total - base), 32'd1);
    req_i = 1'b0;
    fetch_ready_i = 1'b1;
    wait_idle();

    // Branch with two responses in flight: both must be dropped
    rsp_hold = 1'b1;
    branch_to(32'h0000_0100);
    run(2);
    branch_to(32'h0000_0200);
    rsp_hold = 1'b0;
    chk("discard_busy", 32'(busy_o), 32'd1);
    exp_push(32'h0000_0200);
    exp_push(32'h0000_0204);
    run(2);
    wait_idle();

    // Strict OBI: branch while waiting for grant holds the old address
    branch_to(32'h0000_0300);
    instr_gnt_i = 1'b0;
    req_i = 1'b1;
    @(negedge clk);
    chk("wg_req", 32'(instr_req_o), 32'd1);
    chk("wg_addr", instr_addr_o, 32'h0000_0300);
    step();
    branch_addr_i = 32'h0000_0400;
    branch_i = 1'b1;
    @(negedge clk);
    chk("wgbr_addr_held", instr_addr_o, 32'h0000_0300);
    step();
    branch_i = 1'b0;
    req_i = 1'b0;
    @(negedge clk);
    chk("wgbr_addr_still", instr_addr_o, 32'h0000_0300);
    chk("wgbr_req_kept", 32'(instr_req_o), 32'd1);
    chk("wgbr_busy", 32'(busy_o), 32'd1);
    step();
    instr_gnt_i = 1'b1;
    @(negedge clk);
    chk("wgbr_gnt_addr", instr_addr_o, 32'h0000_0300);
    step();
    exp_push(32'h0000_0400);
    req_i = 1'b1;
    @(negedge clk);
    chk("after_br_addr", instr_addr_o, 32'h0000_0400);
    chk("after_br_req", 32'(instr_req_o), 32'd1);
    step();
    req_i = 1'b0;
    wait_idle();

    // Bypass: response into an empty FIFO is visible in the same cycle
    branch_to(32'h0000_0600);
    exp_push(32'h0000_0600);
    run(1);
    @(negedge clk);
    chk("bypass_valid", 32'(fetch_valid_o), 32'd1);
    chk("bypass_rdata", fetch_rdata_o, 32'hDEAD_BEEF);
    chk("bypass_level", 32'(level_o), 32'd0);
    step();
    chk("bypass_level_after", 32'(level_o), 32'd0);
    wait_idle();

    // Bus error tags one word only; unaligned target is word-aligned
    branch_to(32'h0000_0502);
    exp_push(32'h0000_0500);
    exp_push(32'h0000_0504);
    run(2);
    wait_idle();

    // Address wraps from the top word to zero
    branch_to(32'hFFFF_FFFF);
    exp_push(32'hFFFF_FFFC);
    exp_push(32'h0000_0000);
    run(2);
    wait_idle();

    // Asynchronous reset mid-burst
    fetch_ready_i = 1'b0;
    branch_to(32'h0000_0700);
    req_i = 1'b1;
    repeat (3) step();
    chk("pre_rst_level", 32'(level_o), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_instr_req", 32'(instr_req_o), 32'd0);
    chk("mid_rst_instr_addr", instr_addr_o, 32'd0);
    chk("mid_rst_fetch_valid", 32'(fetch_valid_o), 32'd0);
    chk("mid_rst_fetch_rdata", fetch_rdata_o, 32'd0);
    chk("mid_rst_fetch_addr", fetch_addr_o, 32'd0);
    chk("mid_rst_fetch_err", 32'(fetch_err_o), 32'd0);
    chk("mid_rst_level", 32'(level_o), 32'd0);
    chk("mid_rst_busy", 32'(busy_o), 32'd0);
    req_i = 1'b0;
    fetch_ready_i = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    chk("post_rst_level", 32'(level_o), 32'd0);
    chk("post_rst_valid", 32'(fetch_valid_o), 32'd0);
    chk("post_rst_scoreboard", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
